// File: rtl/packet_sink_pkg.sv
// Shared definitions for the packet_sink traffic checker: flit layout helpers and FSM states.
package packet_sink_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BODY  = 2'd1,
        ST_DRAIN = 2'd2
    } sink_state_t;

    // Flit layout is {last, addr, data}, so these must agree with the generator side.
    function automatic int flit_last_bit(input int data_size, input int addr_size);
        return data_size + addr_size;
    endfunction

    function automatic int flit_addr_lsb(input int data_size);
        return data_size;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sink_stall_gen.sv
// Programmable back-pressure source for packet_sink: drops ready one cycle in every STALL_PERIOD.
module sink_stall_gen #(
    parameter int STALL_PERIOD = 0
) (
    input  logic clk,
    input  logic a_rst,
    output logic out_r
);

    localparam int CNT_W = $clog2(STALL_PERIOD) + 1;

    logic [CNT_W-1:0] cnt;

    // Ready reflects the counter value before it advances, giving a 1,1,..,0 pattern.
    always_ff @(posedge clk) begin
        if (a_rst) begin
            cnt   <= CNT_W'(1);
            out_r <= 1'b0;
        end else if (STALL_PERIOD == 0) begin
            out_r <= 1'b1;
        end else begin
            out_r <= (cnt != '0);
            cnt   <= (cnt == CNT_W'(STALL_PERIOD - 1)) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/packet_sink.sv
// NoC local-port traffic sink: accepts flits, checks address/structure/length/payload, keeps counters.
module packet_sink
    import packet_sink_pkg::*;
#(
    parameter int DATA_SIZE      = 8,
    parameter int ADDR_SIZE      = 4,
    parameter int ADDR           = 0,
    parameter int NODES_NUM      = 9,
    parameter int MAX_PACK_LEN   = 8,
    parameter int PACKS_EXPECTED = 16,
    parameter int STALL_PERIOD   = 0,
    parameter int DEBUG          = 0
) (
    input  logic                           clk,
    input  logic                           a_rst,
    input  logic [DATA_SIZE+ADDR_SIZE:0]   data_i,
    input  logic                           in_w,
    output logic                           out_r,
    output logic [31:0]                    pack_cnt,
    output logic [31:0]                    flit_cnt,
    output logic [15:0]                    err_cnt,
    output logic                           err_o,
    output logic [ADDR_SIZE-1:0]           last_src,
    output logic                           done
);

    localparam int LAST_BIT = flit_last_bit(DATA_SIZE, ADDR_SIZE);
    localparam int ADDR_LSB = flit_addr_lsb(DATA_SIZE);
    localparam int IDX_W    = max_int(DATA_SIZE, $clog2(MAX_PACK_LEN + 1) + 1);

    if (STALL_PERIOD == 1 || STALL_PERIOD < 0 || ADDR_SIZE > DATA_SIZE ||
        MAX_PACK_LEN < 1 || (DEBUG != 0 && DEBUG != 1)) begin : g_bad_params
        $error("packet_sink: illegal parameter combination");
    end

    sink_state_t            state;
    logic [IDX_W-1:0]       flit_idx;
    logic [ADDR_SIZE-1:0]   src_q;

    logic                   flit_last;
    logic [ADDR_SIZE-1:0]   flit_addr;
    logic [DATA_SIZE-1:0]   flit_data;
    logic [ADDR_SIZE-1:0]   head_src;
    logic                   accept;
    logic                   addr_err;
    logic                   src_err;
    logic                   pat_err;
    logic                   len_over;
    logic                   flit_err;
    logic                   complete;
    logic [ADDR_SIZE-1:0]   complete_src;
    logic [31:0]            pack_next;

    sink_stall_gen #(
        .STALL_PERIOD(STALL_PERIOD)
    ) u_stall (
        .clk  (clk),
        .a_rst(a_rst),
        .out_r(out_r)
    );

    assign flit_last = data_i[LAST_BIT];
    assign flit_addr = data_i[ADDR_LSB +: ADDR_SIZE];
    assign flit_data = data_i[DATA_SIZE-1:0];
    assign head_src  = flit_data[ADDR_SIZE-1:0];
    assign accept    = in_w && out_r;
    assign pack_next = pack_cnt + 32'd1;

    // All error sources of one flit collapse into a single error event.
    always_comb begin
        addr_err     = (flit_addr != ADDR_SIZE'(ADDR));
        src_err      = (32'(head_src) >= 32'(NODES_NUM));
        pat_err      = (flit_data != flit_idx[DATA_SIZE-1:0]);
        len_over     = (flit_idx == IDX_W'(MAX_PACK_LEN)) && !flit_last;
        flit_err     = 1'b0;
        complete     = 1'b0;
        complete_src = src_q;
        case (state)
            ST_IDLE: begin
                flit_err     = addr_err || src_err;
                complete     = flit_last;
                complete_src = head_src;
            end
            ST_BODY: begin
                flit_err = addr_err || pat_err || len_over;
                complete = flit_last;
            end
            default: begin
                flit_err = 1'b0;
                complete = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (a_rst) begin
            state    <= ST_IDLE;
            flit_idx <= '0;
            src_q    <= '0;
            pack_cnt <= '0;
            flit_cnt <= '0;
            err_cnt  <= '0;
            err_o    <= 1'b0;
            last_src <= '0;
            done     <= 1'b0;
        end else begin
            err_o <= 1'b0;
            if (accept) begin
                flit_cnt <= flit_cnt + 32'd1;
                if (flit_err) begin
                    err_o <= 1'b1;
                    if (err_cnt != 16'hFFFF) begin
                        err_cnt <= err_cnt + 16'd1;
                    end
                end
                if (complete) begin
                    pack_cnt <= pack_next;
                    last_src <= complete_src;
                    if (pack_next >= 32'(PACKS_EXPECTED)) begin
                        done <= 1'b1;
                    end
                end
                // Packets that overflow are drained up to their last flit and never counted.
                case (state)
                    ST_IDLE: begin
                        if (!flit_last) begin
                            state    <= ST_BODY;
                            flit_idx <= IDX_W'(1);
                            src_q    <= head_src;
                        end
                    end
                    ST_BODY: begin
                        if (flit_last) begin
                            state    <= ST_IDLE;
                            flit_idx <= '0;
                        end else if (len_over) begin
                            state <= ST_DRAIN;
                        end else begin
                            flit_idx <= flit_idx + IDX_W'(1);
                        end
                    end
                    default: begin
                        if (flit_last) begin
                            state    <= ST_IDLE;
                            flit_idx <= '0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_packet_sink.sv
// Directed bench for packet_sink: vector table for packet traffic plus reset, done and stall sequences.
module tb_packet_sink;

    logic        clk = 1'b0;
    logic        a_rst;
    logic [12:0] data_i;
    logic        in_w;
    logic        out_r;
    logic [31:0] pack_cnt;
    logic [31:0] flit_cnt;
    logic [15:0] err_cnt;
    logic        err_o;
    logic [3:0]  last_src;
    logic        done;

    logic [12:0] s_data_i;
    logic        s_in_w;
    logic        s_out_r;
    logic [31:0] s_pack_cnt;
    logic [31:0] s_flit_cnt;
    logic [15:0] s_err_cnt;
    logic        s_err_o;
    logic [3:0]  s_last_src;
    logic        s_done;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        int w;
        int last;
        int addr;
        int data;
        int pack;
        int flit;
        int err;
        int err_o;
        int src;
    } vec_t;

    vec_t vecs[19];

    always #5 clk = ~clk;

    packet_sink #(
        .MAX_PACK_LEN(4),
        .STALL_PERIOD(0)
    ) dut (
        .clk     (clk),
        .a_rst   (a_rst),
        .data_i  (data_i),
        .in_w    (in_w),
        .out_r   (out_r),
        .pack_cnt(pack_cnt),
        .flit_cnt(flit_cnt),
        .err_cnt (err_cnt),
        .err_o   (err_o),
        .last_src(last_src),
        .done    (done)
    );

    packet_sink #(
        .STALL_PERIOD(3)
    ) dut_stall (
        .clk     (clk),
        .a_rst   (a_rst),
        .data_i  (s_data_i),
        .in_w    (s_in_w),
        .out_r   (s_out_r),
        .pack_cnt(s_pack_cnt),
        .flit_cnt(s_flit_cnt),
        .err_cnt (s_err_cnt),
        .err_o   (s_err_o),
        .last_src(s_last_src),
        .done    (s_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input int w, input int last, input int addr, input int data);
        logic [31:0] l;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] wv;
        l  = 32'(last);
        a  = 32'(addr);
        d  = 32'(data);
        wv = 32'(w);
        in_w   = wv[0];
        data_i = {l[0], a[3:0], d[7:0]};
    endtask

    task automatic check_counters(input string tag, input int pack, input int flit, input int err,
                                  input int erro, input int src);
        check_output({tag, ".pack"},  pack_cnt,        32'(pack));
        check_output({tag, ".flit"},  flit_cnt,        32'(flit));
        check_output({tag, ".err"},   32'(err_cnt),    32'(err));
        check_output({tag, ".err_o"}, 32'(err_o),      32'(erro));
        check_output({tag, ".src"},   32'(last_src),   32'(src));
    endtask

    initial begin
        int exp_flits;
        logic exp_rdy;

        //        w  l addr data   pack flit err err_o src
        vecs[0]  = '{1, 1, 0, 3,    1, 1,  0, 0, 3};
        vecs[1]  = '{1, 0, 0, 2,    1, 2,  0, 0, 3};
        vecs[2]  = '{1, 0, 0, 1,    1, 3,  0, 0, 3};
        vecs[3]  = '{1, 0, 0, 2,    1, 4,  0, 0, 3};
        vecs[4]  = '{1, 1, 0, 3,    2, 5,  0, 0, 2};
        vecs[5]  = '{0, 0, 0, 0,    2, 5,  0, 0, 2};
        vecs[6]  = '{1, 0, 0, 5,    2, 6,  0, 0, 2};
        vecs[7]  = '{1, 0, 0, 1,    2, 7,  0, 0, 2};
        vecs[8]  = '{1, 1, 7, 5,    3, 8,  1, 1, 5};
        vecs[9]  = '{0, 0, 0, 0,    3, 8,  1, 0, 5};
        vecs[10] = '{1, 1, 4, 9,    4, 9,  2, 1, 9};
        vecs[11] = '{0, 0, 0, 0,    4, 9,  2, 0, 9};
        vecs[12] = '{1, 0, 0, 1,    4, 10, 2, 0, 9};
        vecs[13] = '{1, 0, 0, 1,    4, 11, 2, 0, 9};
        vecs[14] = '{1, 0, 0, 2,    4, 12, 2, 0, 9};
        vecs[15] = '{1, 0, 0, 3,    4, 13, 2, 0, 9};
        vecs[16] = '{1, 0, 0, 4,    4, 14, 3, 1, 9};
        vecs[17] = '{1, 1, 3, 170,  4, 15, 3, 0, 9};
        vecs[18] = '{1, 1, 0, 6,    5, 16, 3, 0, 6};

        a_rst    = 1'b1;
        in_w     = 1'b0;
        data_i   = '0;
        s_in_w   = 1'b0;
        s_data_i = {1'b1, 4'd0, 8'd2};
        step();
        step();
        check_counters("reset", 0, 0, 0, 0, 0);
        check_output("reset.out_r", 32'(out_r), 32'd0);
        check_output("reset.done",  32'(done),  32'd0);
        a_rst = 1'b0;
        step();
        check_output("release.out_r", 32'(out_r), 32'd1);

        for (int i = 0; i < 19; i++) begin
            apply_stimulus(vecs[i].w, vecs[i].last, vecs[i].addr, vecs[i].data);
            step();
            check_counters($sformatf("v%0d", i), vecs[i].pack, vecs[i].flit, vecs[i].err,
                           vecs[i].err_o, vecs[i].src);
        end
        apply_stimulus(0, 0, 0, 0);

        // Reset lands on the second flit of a packet, which must be discarded.
        apply_stimulus(1, 0, 0, 2);
        step();
        apply_stimulus(1, 0, 0, 1);
        a_rst = 1'b1;
        step();
        check_counters("midrst", 0, 0, 0, 0, 0);
        check_output("midrst.out_r", 32'(out_r), 32'd0);
        a_rst = 1'b0;
        apply_stimulus(0, 0, 0, 0);
        step();
        apply_stimulus(1, 0, 0, 4);
        step();
        apply_stimulus(1, 1, 0, 1);
        step();
        check_counters("fresh", 1, 2, 0, 0, 4);
        check_output("fresh.done", 32'(done), 32'd0);

        for (int i = 0; i < 14; i++) begin
            apply_stimulus(1, 1, 0, 1);
            step();
        end
        check_output("done15.pack", pack_cnt, 32'd15);
        check_output("done15.done", 32'(done), 32'd0);
        apply_stimulus(1, 1, 0, 1);
        step();
        check_output("done16.pack", pack_cnt, 32'd16);
        check_output("done16.done", 32'(done), 32'd1);
        apply_stimulus(0, 0, 0, 0);
        step();
        step();
        step();
        check_output("done.sticky", 32'(done), 32'd1);

        // Stalling sink with the write strobe held high through reset release.
        a_rst  = 1'b1;
        s_in_w = 1'b1;
        step();
        a_rst = 1'b0;
        exp_flits = 0;
        for (int k = 1; k <= 9; k++) begin
            step();
            exp_rdy = (k % 3) != 0;
            check_output($sformatf("stall%0d.out_r", k), 32'(s_out_r), 32'(exp_rdy));
            check_output($sformatf("stall%0d.flit", k),  s_flit_cnt, 32'(exp_flits));
            check_output($sformatf("stall%0d.pack", k),  s_pack_cnt, 32'(exp_flits));
            if (exp_rdy) exp_flits++;
        end
        s_in_w = 1'b0;
        step();
        check_output("stall.final_flit", s_flit_cnt, 32'(exp_flits));
        check_output("stall.err", 32'(s_err_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
